// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/gnt/rvalid bus between fetch and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC, single-outstanding imem requests, {pc, instr} prefetch buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_if,
  input  logic                pc_src,
  input  logic [31:0]         new_pc,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr_if,
  output logic [31:0]         pc_if,
  output logic                valid_if
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT         = 2'd1,
    S_WAIT_DISCARD = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_req_pc;
  logic [31:0]     r_pc_hold;
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_buf_pc    [BUF_DEPTH];
  logic [31:0]     r_buf_instr [BUF_DEPTH];

  logic            w_busy;
  logic            w_req;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW:0]     w_reserved;

  // A request is only issued when a buffer slot is guaranteed for its response.
  assign w_busy     = (r_state != S_IDLE);
  assign w_reserved = {1'b0, r_count} + (CW+1)'(w_busy);
  assign w_req      = rst && (r_state == S_IDLE) && !pc_src
                      && (w_reserved < (CW+1)'(BUF_DEPTH));
  assign w_fire     = w_req && imem.imem_gnt;
  assign w_push     = (r_state == S_WAIT) && imem.imem_rvalid && !pc_src;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && !stall_if && !pc_src;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) w_state_nxt = S_IDLE;
        else if (pc_src)      w_state_nxt = S_WAIT_DISCARD;
      end
      S_WAIT_DISCARD: begin
        if (imem.imem_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_pc_hold  <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      assert (!(w_push && (r_count == CW'(BUF_DEPTH))));
      r_state <= w_state_nxt;
      if (w_fire) r_req_pc <= r_fetch_pc;
      if (w_valid) r_pc_hold <= r_buf_pc[r_head];
      if (pc_src) begin
        r_fetch_pc <= new_pc & 32'hFFFF_FFFC;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) begin
          r_buf_pc[r_tail]    <= r_req_pc;
          r_buf_instr[r_tail] <= imem.imem_rdata;
          r_tail              <= r_tail + PW'(1);
        end
        if (w_pop) r_head <= r_head + PW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;
  assign valid_if       = w_valid;
  assign instr_if       = w_valid ? r_buf_instr[r_head] : NOP_INSTR;
  assign pc_if          = w_valid ? r_buf_pc[r_head]    : r_pc_hold;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        pc_src;
  logic [31:0] new_pc;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        valid_if;

  int n_cmp = 0;
  int n_err = 0;

  // memory model state
  logic        m_pend = 1'b0;
  int          m_wait = 0;
  int          m_delay = 0;
  logic [31:0] m_addr = 32'h0;

  fetch_stage_if u_if ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .NOP_INSTR (32'h0000_0013)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .stall_if (stall_if),
    .pc_src   (pc_src),
    .new_pc   (new_pc),
    .imem     (u_if.master),
    .instr_if (instr_if),
    .pc_if    (pc_if),
    .valid_if (valid_if)
  );

  always #5 clk = ~clk;

  // Responds m_delay+1 cycles after the accepting cycle; rdata = addr | 0xA000_0000.
  always @(negedge clk) begin
    u_if.imem_rvalid = 1'b0;
    if (m_pend) begin
      if (m_wait == 0) begin
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata  = m_addr | 32'hA000_0000;
        m_pend = 1'b0;
      end else begin
        m_wait = m_wait - 1;
      end
    end
    if (rst && u_if.imem_req && u_if.imem_gnt) begin
      m_pend = 1'b1;
      m_addr = u_if.imem_addr;
      m_wait = m_delay;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall_if = 1'b0; pc_src = 1'b0; new_pc = 32'h0;
    u_if.imem_gnt = 1'b1; u_if.imem_rvalid = 1'b0; u_if.imem_rdata = 32'h0;
    step(); step();
    chk("rst_valid", {31'h0, valid_if}, 32'h0);
    chk("rst_instr", instr_if, 32'h0000_0013);
    chk("rst_pc", pc_if, 32'h0);
    chk("rst_req", {31'h0, u_if.imem_req}, 32'h0);
    chk("rst_addr", u_if.imem_addr, 32'h0);

    rst = 1'b1; #1;
    chk("run_req0", {31'h0, u_if.imem_req}, 32'h1);
    chk("run_addr0", u_if.imem_addr, 32'h0);
    step();
    chk("run_wait_req", {31'h0, u_if.imem_req}, 32'h0);
    chk("run_wait_valid", {31'h0, valid_if}, 32'h0);
    step();
    chk("run_valid0", {31'h0, valid_if}, 32'h1);
    chk("run_pc0", pc_if, 32'h0);
    chk("run_instr0", instr_if, 32'hA000_0000);
    chk("run_addr4", u_if.imem_addr, 32'h4);
    step();
    chk("run_gap_valid", {31'h0, valid_if}, 32'h0);
    chk("run_gap_nop", instr_if, 32'h0000_0013);
    chk("run_gap_pc", pc_if, 32'h0);
    step();
    chk("run_pc4", pc_if, 32'h4);
    chk("run_instr4", instr_if, 32'hA000_0004);
    chk("run_addr8", u_if.imem_addr, 32'h8);

    stall_if = 1'b1;
    step();
    chk("stall_wait_req", {31'h0, u_if.imem_req}, 32'h0);
    step();
    chk("stall_full_req", {31'h0, u_if.imem_req}, 32'h0);
    chk("stall_head_pc", pc_if, 32'h4);
    repeat (8) step();
    chk("stall_hold_req", {31'h0, u_if.imem_req}, 32'h0);
    chk("stall_hold_pc", pc_if, 32'h4);
    chk("stall_hold_instr", instr_if, 32'hA000_0004);
    stall_if = 1'b0;
    step();
    chk("drain_pc8", pc_if, 32'h8);
    chk("drain_instr8", instr_if, 32'hA000_0008);
    chk("drain_req", {31'h0, u_if.imem_req}, 32'h1);
    chk("drain_addrC", u_if.imem_addr, 32'hC);
    step();
    chk("drain_empty", {31'h0, valid_if}, 32'h0);
    step();
    chk("resume_pcC", pc_if, 32'hC);
    chk("resume_addr10", u_if.imem_addr, 32'h10);

    stall_if = 1'b1; m_delay = 2;
    step();
    pc_src = 1'b1; new_pc = 32'h100; #1;
    chk("redir_req_blocked", {31'h0, u_if.imem_req}, 32'h0);
    step();
    pc_src = 1'b0; stall_if = 1'b0; #1;
    chk("redir_flushed", {31'h0, valid_if}, 32'h0);
    chk("redir_hold_pc", pc_if, 32'hC);
    chk("redir_nop", instr_if, 32'h0000_0013);
    chk("redir_discard_req", {31'h0, u_if.imem_req}, 32'h0);
    step();
    chk("redir_discard_req2", {31'h0, u_if.imem_req}, 32'h0);
    step();
    chk("redir_dropped", {31'h0, valid_if}, 32'h0);
    chk("redir_req", {31'h0, u_if.imem_req}, 32'h1);
    chk("redir_addr", u_if.imem_addr, 32'h100);
    m_delay = 0;
    step();
    chk("redir_wait_valid", {31'h0, valid_if}, 32'h0);
    step();
    chk("redir_pc100", pc_if, 32'h100);
    chk("redir_instr100", instr_if, 32'hA000_0100);
    chk("redir_addr104", u_if.imem_addr, 32'h104);

    step();
    pc_src = 1'b1; new_pc = 32'h203; #1;
    chk("coinc_req_blocked", {31'h0, u_if.imem_req}, 32'h0);
    step();
    pc_src = 1'b0; #1;
    chk("coinc_dropped", {31'h0, valid_if}, 32'h0);
    chk("coinc_req", {31'h0, u_if.imem_req}, 32'h1);
    chk("coinc_addr", u_if.imem_addr, 32'h200);
    step();
    step();
    chk("coinc_pc200", pc_if, 32'h200);
    chk("coinc_instr200", instr_if, 32'hA000_0200);

    u_if.imem_gnt = 1'b0;
    step();
    chk("nognt_req1", {31'h0, u_if.imem_req}, 32'h1);
    chk("nognt_addr1", u_if.imem_addr, 32'h204);
    step();
    chk("nognt_req2", {31'h0, u_if.imem_req}, 32'h1);
    chk("nognt_addr2", u_if.imem_addr, 32'h204);
    pc_src = 1'b1; new_pc = 32'h40; #1;
    chk("nognt_redir_req", {31'h0, u_if.imem_req}, 32'h0);
    step();
    pc_src = 1'b0; u_if.imem_gnt = 1'b1; #1;
    chk("nognt_req40", {31'h0, u_if.imem_req}, 32'h1);
    chk("nognt_addr40", u_if.imem_addr, 32'h40);
    step();
    step();
    chk("nognt_pc40", pc_if, 32'h40);
    chk("nognt_addr44", u_if.imem_addr, 32'h44);

    m_delay = 1;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; m_delay = 0; #1;
    chk("rstw_valid", {31'h0, valid_if}, 32'h0);
    chk("rstw_pc", pc_if, 32'h0);
    chk("rstw_req", {31'h0, u_if.imem_req}, 32'h1);
    chk("rstw_addr", u_if.imem_addr, 32'h0);
    step();
    chk("rstw_stale_ignored", {31'h0, valid_if}, 32'h0);
    chk("rstw_wait_req", {31'h0, u_if.imem_req}, 32'h0);
    step();
    chk("rstw_valid0", {31'h0, valid_if}, 32'h1);
    chk("rstw_pc0", pc_if, 32'h0);
    chk("rstw_instr0", instr_if, 32'hA000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
